// File: rtl/timer_apb_master.sv
// Single-outstanding APB master: converts valid/ready register commands into APB
// transfers on the timer slave port and returns read data / error / timeout status.
module timer_apb_master #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    to_q, to_d;
    logic                    timeout_hit;

    // Handshake and APB control strobes are pure state decodes.
    assign cmd_ready   = (state_q == S_IDLE);
    assign PSEL        = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign PENABLE     = (state_q == S_ACCESS);
    assign rsp_valid   = (state_q == S_RESP);
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = to_q;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        to_d     = to_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                // PREADY takes priority over a timeout landing on the same cycle.
                if (PREADY) begin
                    rdata_d = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
                    err_d   = PSLVERR;
                    to_d    = 1'b0;
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                    state_d = S_RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            to_q     <= to_d;
        end
    end

endmodule

// File: tb/tb_timer_apb_master.sv
// Directed bench for timer_apb_master: write, wait-state read, slave error, timeout,
// back-pressure and asynchronous reset during ACCESS.
module tb_timer_apb_master;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA = '0;
    logic       PREADY = 1'b0;
    logic       PSLVERR = 1'b0;

    int checks = 0;
    int failures = 0;
    int acc;
    logic [7:0] held_rdata;

    timer_apb_master #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Issues one command and drives PREADY low for `waits` ACCESS cycles (waits<0: never ready).
    // Returns with the DUT expected in RESP and rsp_ready low; acc_o counts ACCESS cycles.
    task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input int waits, input logic slverr, input logic [7:0] prd,
                        output int acc_o);
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
        tick();
        acc_o = 0;
        while (PENABLE === 1'b1 && acc_o < 40) begin
            acc_o++;
            PREADY  = (waits >= 0) && (acc_o > waits);
            PSLVERR = slverr;
            PRDATA  = prd;
            tick();
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_psel", PSEL, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_paddr", PADDR, 8'h00);
        tick();
        tick();
        PRESET = 1'b0;
        tick();

        // 1: zero-wait write
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h00; cmd_wdata = 8'hA5; PREADY = 1'b1;
        check("t1_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("t1_setup_psel", {PSEL, PENABLE}, 2'b10);
        check("t1_setup_pwdata", PWDATA, 8'hA5);
        check("t1_setup_pwrite", PWRITE, 1);
        check("t1_setup_cmd_ready", cmd_ready, 0);
        tick();
        check("t1_access_psel", {PSEL, PENABLE}, 2'b11);
        check("t1_access_pwdata", PWDATA, 8'hA5);
        check("t1_access_rsp_valid", rsp_valid, 0);
        tick();
        PREADY = 1'b0;
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_rsp_psel", {PSEL, PENABLE}, 2'b00);
        check("t1_rsp_err", rsp_err, 0);
        check("t1_rsp_rdata", rsp_rdata, 8'h00);
        handshake();
        check("t1_idle_cmd_ready", cmd_ready, 1);
        check("t1_idle_rsp_valid", rsp_valid, 0);

        // 2: read with 3 wait states
        xfer(1'b0, 8'h02, 8'h00, 3, 1'b0, 8'h3C, acc);
        check("t2_access_cycles", acc, 4);
        check("t2_rsp_valid", rsp_valid, 1);
        check("t2_rdata", rsp_rdata, 8'h3C);
        check("t2_err", rsp_err, 0);
        check("t2_timeout", rsp_timeout, 0);
        check("t2_paddr", PADDR, 8'h02);
        handshake();

        // 3: slave error on read
        xfer(1'b0, 8'hFF, 8'h00, 0, 1'b1, 8'h77, acc);
        check("t3_access_cycles", acc, 1);
        check("t3_err", rsp_err, 1);
        check("t3_rdata", rsp_rdata, 8'h00);
        check("t3_timeout", rsp_timeout, 0);
        handshake();

        // 4a: timeout with PREADY held low
        xfer(1'b0, 8'h01, 8'h00, -1, 1'b0, 8'h99, acc);
        check("t4a_access_cycles", acc, 16);
        check("t4a_psel", PSEL, 0);
        check("t4a_rsp_valid", rsp_valid, 1);
        check("t4a_err", rsp_err, 1);
        check("t4a_timeout", rsp_timeout, 1);
        check("t4a_rdata", rsp_rdata, 8'h00);
        handshake();

        // 4b: PREADY on the 16th ACCESS cycle completes normally
        xfer(1'b0, 8'h01, 8'h00, 15, 1'b0, 8'h6D, acc);
        check("t4b_access_cycles", acc, 16);
        check("t4b_err", rsp_err, 0);
        check("t4b_timeout", rsp_timeout, 0);
        check("t4b_rdata", rsp_rdata, 8'h6D);
        handshake();

        // 5: response back-pressure blocks new commands
        xfer(1'b0, 8'h01, 8'h00, 0, 1'b0, 8'h5A, acc);
        held_rdata = rsp_rdata;
        check("t5_rdata", held_rdata, 8'h5A);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h03; cmd_wdata = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_rsp_valid", rsp_valid, 1);
            check("t5_hold_rdata", rsp_rdata, held_rdata);
            check("t5_hold_cmd_ready", cmd_ready, 0);
            check("t5_hold_psel", PSEL, 0);
            tick();
        end
        check("t5_hold_paddr", PADDR, 8'h01);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t5_idle_cmd_ready", cmd_ready, 1);
        check("t5_idle_rsp_valid", rsp_valid, 0);
        tick();
        cmd_valid = 1'b0;
        check("t5_new_setup", {PSEL, PENABLE}, 2'b10);
        check("t5_new_paddr", PADDR, 8'h03);
        check("t5_new_pwdata", PWDATA, 8'hC3);
        PREADY = 1'b1;
        tick();
        tick();
        PREADY = 1'b0;
        check("t5_new_rsp_valid", rsp_valid, 1);
        handshake();

        // 6: asynchronous reset while in ACCESS
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h02;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("t6_pre_penable", PENABLE, 1);
        #2;
        PRESET = 1'b1;
        #1;
        check("t6_rst_psel", {PSEL, PENABLE}, 2'b00);
        check("t6_rst_rsp_valid", rsp_valid, 0);
        check("t6_rst_cmd_ready", cmd_ready, 1);
        tick();
        PRESET = 1'b0;
        xfer(1'b1, 8'h00, 8'h11, 1, 1'b0, 8'hEE, acc);
        check("t6_after_access_cycles", acc, 2);
        check("t6_after_rsp_valid", rsp_valid, 1);
        check("t6_after_rdata", rsp_rdata, 8'h00);
        check("t6_after_err", rsp_err, 0);
        check("t6_after_pwdata", PWDATA, 8'h11);
        handshake();
        check("t6_after_idle", cmd_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
